// File: rtl/avm_burst_responder_if.sv
// Avalon-MM burst slave bus bundle for avm_burst_responder.
// master drives commands and write beats; slave returns waitrequest,
// read data and per-beat write acknowledges.
interface avm_burst_responder_if #(
    parameter int AWIDTH           = 32,
    parameter int MWIDTH_BYTES     = 32,
    parameter int BURSTCOUNT_WIDTH = 6
);
    logic [AWIDTH-1:0]           avs_address;
    logic                        avs_read;
    logic                        avs_write;
    logic [8*MWIDTH_BYTES-1:0]   avs_writedata;
    logic [MWIDTH_BYTES-1:0]     avs_byteenable;
    logic [BURSTCOUNT_WIDTH-1:0] avs_burstcount;
    logic                        avs_waitrequest;
    logic [8*MWIDTH_BYTES-1:0]   avs_readdata;
    logic                        avs_readdatavalid;
    logic                        avs_writeack;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
               avs_byteenable, avs_burstcount,
        input  avs_waitrequest, avs_readdata, avs_readdatavalid, avs_writeack
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
               avs_byteenable, avs_burstcount,
        output avs_waitrequest, avs_readdata, avs_readdatavalid, avs_writeack
    );
endinterface

// File: rtl/avm_burst_responder.sv
// Avalon-MM burst slave backed by on-chip RAM. Pipelined burst reads return
// in order after READ_LATENCY cycles; every written beat is acknowledged one
// cycle later. Bursts wrap at the end of the RAM.
// Optional macro RANDOM_WAITREQUEST_EN: an LFSR injects random waitrequest
// stalls in IDLE and WRITE_BURST.
module avm_burst_responder #(
    parameter int          AWIDTH           = 32,
    parameter int          MWIDTH_BYTES     = 32,
    parameter int          BURSTCOUNT_WIDTH = 6,
    parameter int          DEPTH_WORDS      = 1024,
    parameter int          READ_LATENCY     = 2,
    parameter logic [15:0] STALL_SEED       = 16'hACE1
) (
    input  logic                  clock,
    input  logic                  reset,
    avm_burst_responder_if.slave  avs,
    output logic                  o_busy,
    output logic                  o_protocol_error
);
    localparam int DW     = 8 * MWIDTH_BYTES;
    localparam int BSHIFT = $clog2(MWIDTH_BYTES);
    localparam int WADDR  = $clog2(DEPTH_WORDS);

    localparam logic [AWIDTH-1:0] WORD_MASK = AWIDTH'(DEPTH_WORDS - 1) << BSHIFT;
    localparam logic [BURSTCOUNT_WIDTH-1:0] ONE = BURSTCOUNT_WIDTH'(1);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] READ_BURST  = 2'd1;
    localparam logic [1:0] WRITE_BURST = 2'd2;

    logic [1:0]                  state;
    logic [BURSTCOUNT_WIDTH-1:0] remaining;
    logic [WADDR-1:0]            next_word;
    logic                        stall;

    logic [WADDR-1:0]            cmd_word;
    logic [BURSTCOUNT_WIDTH-1:0] cmd_len;
    logic                        rd_fire;
    logic                        wr_fire;
    logic [WADDR-1:0]            rd_word;
    logic [WADDR-1:0]            wr_word;
    logic                        err_set;
    logic                        writeack_q;

    logic [DW-1:0]               mem     [DEPTH_WORDS];
    logic [DW-1:0]               data_sr [READ_LATENCY];
    logic [READ_LATENCY-1:0]     valid_sr;

    // Address bits outside the word index (byte offset, upper bits) are ignored.
    logic unused_bits;
    assign unused_bits = ^{avs.avs_address & ~WORD_MASK, STALL_SEED};

    assign cmd_word = avs.avs_address[BSHIFT +: WADDR];
    assign cmd_len  = (avs.avs_burstcount == '0) ? ONE : avs.avs_burstcount;

`ifdef RANDOM_WAITREQUEST_EN
    logic [15:0] lfsr;

    // Free-running Fibonacci LFSR, taps 16,14,13,11.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= STALL_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall = lfsr[0] & (state != READ_BURST);
`else
    assign stall = 1'b0;
`endif

    // Decide which beat, if any, issues to the RAM this cycle.
    always_comb begin
        rd_fire = 1'b0;
        wr_fire = 1'b0;
        rd_word = next_word;
        wr_word = next_word;
        err_set = 1'b0;
        case (state)
            IDLE: begin
                if (!stall) begin
                    if (avs.avs_write) begin
                        wr_fire = 1'b1;
                        wr_word = cmd_word;
                    end else if (avs.avs_read) begin
                        rd_fire = 1'b1;
                        rd_word = cmd_word;
                    end
                    // Simultaneous read+write keeps the write and drops the read.
                    err_set = (avs.avs_read & avs.avs_write) |
                              ((avs.avs_read | avs.avs_write) & (avs.avs_burstcount == '0));
                end
            end
            READ_BURST: begin
                rd_fire = 1'b1;
            end
            WRITE_BURST: begin
                wr_fire = ~stall & avs.avs_write;
                err_set = avs.avs_read;
            end
            default: ;
        endcase
    end

    // Burst state machine, beat counters, write acknowledge and sticky error.
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            remaining        <= '0;
            next_word        <= '0;
            writeack_q       <= 1'b0;
            o_protocol_error <= 1'b0;
        end else begin
            writeack_q <= wr_fire;
            if (err_set) begin
                o_protocol_error <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (rd_fire || wr_fire) begin
                        next_word <= cmd_word + 1'b1;
                        remaining <= cmd_len - 1'b1;
                        if (cmd_len != ONE) begin
                            state <= wr_fire ? WRITE_BURST : READ_BURST;
                        end
                    end
                end
                READ_BURST, WRITE_BURST: begin
                    if (rd_fire || wr_fire) begin
                        next_word <= next_word + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == ONE) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM with byte-enabled writes; the registered read returns old data on
    // a same-cycle write, then flows through the return data pipeline.
    always_ff @(posedge clock) begin
        if (wr_fire) begin
            for (int unsigned b = 0; b < MWIDTH_BYTES; b++) begin
                if (avs.avs_byteenable[b]) begin
                    mem[wr_word][8*b +: 8] <= avs.avs_writedata[8*b +: 8];
                end
            end
        end
        data_sr[0] <= mem[rd_word];
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            data_sr[i] <= data_sr[i-1];
        end
    end

    // Read-return valid shift register, READ_LATENCY deep.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_sr <= '0;
        end else begin
            valid_sr <= (valid_sr << 1) | READ_LATENCY'(rd_fire);
        end
    end

    assign avs.avs_waitrequest   = (state == READ_BURST) | stall;
    assign avs.avs_readdatavalid = valid_sr[READ_LATENCY-1];
    assign avs.avs_readdata      = valid_sr[READ_LATENCY-1] ? data_sr[READ_LATENCY-1] : '0;
    assign avs.avs_writeack      = writeack_q;
    assign o_busy                = (state != IDLE) | (|valid_sr);
endmodule
